// File: rtl/led_pattern_monitor.sv
// LED pattern bus monitor.
// Samples the LED vector from the pattern generator and classifies every
// change as a rotate-left, rotate-right, invert or alternate step. It locks
// onto a mode after a run of consistent steps and then polices the step
// interval against the generator period. Step, timing and stall faults
// appear as single-cycle pulses and feed a saturating error counter.

// Checker for output invariants that must hold in every state.
module led_pattern_monitor_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [1:0] mode_out,
    input logic       mode_valid,
    input logic       locked,
    input logic       step_pulse,
    input logic       step_err
);

    // A step error is only ever raised on a detected change.
    a_step_err_on_change: assert property (@(posedge clk) disable iff (!rst_n)
        step_err |-> step_pulse);

    // Locking requires a candidate mode.
    a_locked_has_mode: assert property (@(posedge clk) disable iff (!rst_n)
        locked |-> mode_valid);

    // Without a candidate the decoded mode reads as zero.
    a_mode_zero_when_invalid: assert property (@(posedge clk) disable iff (!rst_n)
        !mode_valid |-> (mode_out == 2'b00));

endmodule

module led_pattern_monitor #(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int unsigned TOL         = 2,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned CNT_W       = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] led_in,
    input  logic [1:0] expected_mode,
    input  logic       check_en,
    output logic [1:0] mode_out,
    output logic       mode_valid,
    output logic       locked,
    output logic       step_pulse,
    output logic       step_err,
    output logic       timing_err,
    output logic       mode_mismatch,
    output logic [7:0] err_count
);

    localparam int unsigned PERIOD = TICK_CYCLES + 1;
    localparam int unsigned RUN_W  = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    // Interval window is compared one bit wider than the counter so that
    // interval = counter + 1 never wraps.
    localparam logic [CNT_W:0]   LO_LIM    = (CNT_W+1)'(PERIOD - TOL);
    localparam logic [CNT_W:0]   HI_LIM    = (CNT_W+1)'(PERIOD + TOL);
    localparam logic [CNT_W:0]   INT_ONE   = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(PERIOD + TOL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [RUN_W-1:0] RUN_LOCK  = RUN_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        CLS_L   = 3'd0,
        CLS_R   = 3'd1,
        CLS_INV = 3'd2,
        CLS_ALT = 3'd3,
        CLS_AMB = 3'd4,
        CLS_UNK = 3'd5
    } step_cls_e;

    // Classify a prev->new LED pair; earlier tests take priority.
    function automatic step_cls_e classify(input logic [7:0] p, input logic [7:0] n);
        step_cls_e c;
        if ((p == 8'hAA && n == 8'h55) || (p == 8'h55 && n == 8'hAA)) begin
            c = CLS_AMB;
        end else if ((n == {p[6:0], 1'b0}) || (p == 8'h80 && n == 8'h01)) begin
            c = CLS_L;
        end else if ((n == {1'b0, p[7:1]}) || (p == 8'h01 && n == 8'h80)) begin
            c = CLS_R;
        end else if (n == ~p) begin
            c = CLS_INV;
        end else if (n == 8'hAA) begin
            c = CLS_ALT;
        end else begin
            c = CLS_UNK;
        end
        return c;
    endfunction

    // Mode code a step class points to. AA<->55 is also an inversion, so an
    // ambiguous step that has to restart tracking restarts on invert.
    function automatic logic [1:0] cls_mode(input step_cls_e c);
        logic [1:0] m;
        case (c)
            CLS_L:   m = 2'b00;
            CLS_R:   m = 2'b01;
            CLS_INV: m = 2'b10;
            CLS_ALT: m = 2'b11;
            CLS_AMB: m = 2'b10;
            default: m = 2'b00;
        endcase
        return m;
    endfunction

    localparam state_e RESTART_ST = (RUN_ONE >= RUN_LOCK) ? ST_LOCKED : ST_TRACK;

    logic [7:0]       led_q_r;
    logic [7:0]       prev_r;
    logic             primed_r;
    logic [CNT_W-1:0] cnt_r;
    state_e           state_r;
    logic [1:0]       cand_r;
    logic [RUN_W-1:0] run_r;
    logic [1:0]       mode_out_r;
    logic             mode_valid_r;
    logic             locked_r;
    logic             step_pulse_r;
    logic             step_err_r;
    logic             timing_err_r;
    logic             mode_mismatch_r;
    logic [7:0]       err_count_r;

    logic             change_s;
    step_cls_e        cls_s;
    logic [1:0]       new_cand_s;
    logic             is_mode_cls_s;
    logic             consistent_s;
    logic [CNT_W:0]   interval_s;
    logic             timing_ok_s;
    logic             stall_s;
    logic [RUN_W-1:0] run_inc_s;
    state_e           state_nx_s;
    logic [1:0]       cand_nx_s;
    logic [RUN_W-1:0] run_nx_s;
    logic             valid_nx_s;
    logic             serr_nx_s;
    logic             terr_nx_s;

    // Change detection, step classification and interval checks.
    always_comb begin
        change_s      = primed_r & (led_q_r != prev_r);
        cls_s         = classify(prev_r, led_q_r);
        new_cand_s    = cls_mode(cls_s);
        is_mode_cls_s = (cls_s == CLS_L) || (cls_s == CLS_R) ||
                        (cls_s == CLS_INV) || (cls_s == CLS_ALT);
        if (cls_s == CLS_AMB) begin
            consistent_s = (cand_r == 2'b10) || (cand_r == 2'b11);
        end else if (is_mode_cls_s) begin
            consistent_s = (new_cand_s == cand_r);
        end else begin
            consistent_s = 1'b0;
        end
        interval_s  = {1'b0, cnt_r} + INT_ONE;
        timing_ok_s = (interval_s >= LO_LIM) && (interval_s <= HI_LIM);
        stall_s     = (cnt_r >= STALL_LIM);
        run_inc_s   = run_r + RUN_ONE;
    end

    // Mode-tracking FSM: next state, candidate, run length and error pulses.
    always_comb begin
        state_nx_s = state_r;
        cand_nx_s  = cand_r;
        run_nx_s   = run_r;
        valid_nx_s = mode_valid_r;
        serr_nx_s  = 1'b0;
        terr_nx_s  = 1'b0;
        case (state_r)
            ST_SEARCH: begin
                if (change_s && is_mode_cls_s) begin
                    state_nx_s = RESTART_ST;
                    cand_nx_s  = new_cand_s;
                    run_nx_s   = RUN_ONE;
                    valid_nx_s = 1'b1;
                end else begin
                    valid_nx_s = 1'b0;
                end
            end
            ST_TRACK: begin
                if (!change_s) begin
                    state_nx_s = ST_TRACK;
                end else if (cls_s == CLS_UNK) begin
                    state_nx_s = ST_SEARCH;
                    cand_nx_s  = 2'b00;
                    run_nx_s   = {RUN_W{1'b0}};
                    valid_nx_s = 1'b0;
                end else if (consistent_s) begin
                    run_nx_s = run_inc_s;
                    if (run_inc_s >= RUN_LOCK) begin
                        state_nx_s = ST_LOCKED;
                    end else begin
                        state_nx_s = ST_TRACK;
                    end
                end else begin
                    state_nx_s = RESTART_ST;
                    cand_nx_s  = new_cand_s;
                    run_nx_s   = RUN_ONE;
                end
            end
            ST_LOCKED: begin
                if (change_s) begin
                    terr_nx_s = ~timing_ok_s;
                    if (!consistent_s) begin
                        serr_nx_s = 1'b1;
                        if (cls_s == CLS_UNK) begin
                            state_nx_s = ST_SEARCH;
                            cand_nx_s  = 2'b00;
                            run_nx_s   = {RUN_W{1'b0}};
                            valid_nx_s = 1'b0;
                        end else begin
                            state_nx_s = ST_TRACK;
                            cand_nx_s  = new_cand_s;
                            run_nx_s   = RUN_ONE;
                        end
                    end else if (!timing_ok_s) begin
                        state_nx_s = ST_TRACK;
                        run_nx_s   = RUN_ONE;
                    end else begin
                        state_nx_s = ST_LOCKED;
                    end
                end else if (stall_s) begin
                    terr_nx_s  = 1'b1;
                    state_nx_s = ST_SEARCH;
                    cand_nx_s  = 2'b00;
                    run_nx_s   = {RUN_W{1'b0}};
                    valid_nx_s = 1'b0;
                end else begin
                    state_nx_s = ST_LOCKED;
                end
            end
            default: begin
                state_nx_s = ST_SEARCH;
                cand_nx_s  = 2'b00;
                run_nx_s   = {RUN_W{1'b0}};
                valid_nx_s = 1'b0;
            end
        endcase
    end

    // Input capture and priming: the first post-reset sample only seeds prev.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q_r  <= 8'h00;
            prev_r   <= 8'h00;
            primed_r <= 1'b0;
        end else begin
            led_q_r <= led_in;
            if (!primed_r) begin
                prev_r   <= led_in;
                primed_r <= 1'b1;
            end else if (change_s) begin
                prev_r <= led_q_r;
            end
        end
    end

    // Interval counter: restarts on each change and saturates at full scale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (change_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_SEARCH;
            cand_r  <= 2'b00;
            run_r   <= {RUN_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cand_r  <= cand_nx_s;
            run_r   <= run_nx_s;
        end
    end

    // Registered status outputs and single-cycle event pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_out_r      <= 2'b00;
            mode_valid_r    <= 1'b0;
            locked_r        <= 1'b0;
            step_pulse_r    <= 1'b0;
            step_err_r      <= 1'b0;
            timing_err_r    <= 1'b0;
            mode_mismatch_r <= 1'b0;
        end else begin
            mode_out_r      <= valid_nx_s ? cand_nx_s : 2'b00;
            mode_valid_r    <= valid_nx_s;
            locked_r        <= (state_nx_s == ST_LOCKED);
            step_pulse_r    <= change_s;
            step_err_r      <= serr_nx_s;
            timing_err_r    <= terr_nx_s;
            mode_mismatch_r <= check_en & locked_r & (mode_out_r != expected_mode);
        end
    end

    // Saturating error counter; a coincident step and timing error counts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_r <= 8'h00;
        end else if ((serr_nx_s || terr_nx_s) && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'h01;
        end
    end

    assign mode_out      = mode_out_r;
    assign mode_valid    = mode_valid_r;
    assign locked        = locked_r;
    assign step_pulse    = step_pulse_r;
    assign step_err      = step_err_r;
    assign timing_err    = timing_err_r;
    assign mode_mismatch = mode_mismatch_r;
    assign err_count     = err_count_r;

    led_pattern_monitor_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_out   (mode_out_r),
        .mode_valid (mode_valid_r),
        .locked     (locked_r),
        .step_pulse (step_pulse_r),
        .step_err   (step_err_r)
    );

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Directed bench for led_pattern_monitor with a cycle-stamped scoreboard:
// each stimulus step pushes the outputs it should produce at a given clock
// edge; a monitor pops and compares them on the falling edge.
module tb_led_pattern_monitor;

    localparam int unsigned TICK_CYCLES = 9;
    localparam int unsigned TOL         = 1;
    localparam int unsigned LOCK_COUNT  = 3;
    localparam int unsigned CNT_W       = 8;

    localparam int S_STEP  = 0;
    localparam int S_SERR  = 1;
    localparam int S_TERR  = 2;
    localparam int S_MODE  = 3;
    localparam int S_VALID = 4;
    localparam int S_LOCK  = 5;
    localparam int S_MISM  = 6;
    localparam int S_ECNT  = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic [1:0] expected_mode = 2'b00;
    logic       check_en = 1'b0;
    logic [1:0] mode_out;
    logic       mode_valid;
    logic       locked;
    logic       step_pulse;
    logic       step_err;
    logic       timing_err;
    logic       mode_mismatch;
    logic [7:0] err_count;

    led_pattern_monitor #(
        .TICK_CYCLES (TICK_CYCLES),
        .TOL         (TOL),
        .LOCK_COUNT  (LOCK_COUNT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .led_in        (led_in),
        .expected_mode (expected_mode),
        .check_en      (check_en),
        .mode_out      (mode_out),
        .mode_valid    (mode_valid),
        .locked        (locked),
        .step_pulse    (step_pulse),
        .step_err      (step_err),
        .timing_err    (timing_err),
        .mode_mismatch (mode_mismatch),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         cyc;
        int         sel;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   ecount = 0;
    int   checks = 0;
    int   errors = 0;

    // Count rising edges so expectations can name the edge they belong to.
    initial begin : edge_counter
        forever begin
            @(posedge clk);
            ecount = ecount + 1;
        end
    end

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            S_STEP:  return {7'd0, step_pulse};
            S_SERR:  return {7'd0, step_err};
            S_TERR:  return {7'd0, timing_err};
            S_MODE:  return {6'd0, mode_out};
            S_VALID: return {7'd0, mode_valid};
            S_LOCK:  return {7'd0, locked};
            S_MISM:  return {7'd0, mode_mismatch};
            S_ECNT:  return err_count;
            default: return 8'h00;
        endcase
    endfunction

    // Pop and compare every expectation due at the current edge.
    initial begin : monitor
        exp_t       e;
        logic [7:0] obs;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= ecount) begin
                e   = sb_q.pop_front();
                obs = pick(e.sel);
                checks = checks + 1;
                assert (obs === e.exp && e.cyc == ecount) else begin
                    errors = errors + 1;
                    $error("FAIL %s edge=%0d sel=%0d observed=%0h expected=%0h",
                           e.tag, e.cyc, e.sel, obs, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue an expectation dly edges from now, kept sorted by edge.
    task automatic expect_at(input string tag, input int dly, input int sel, input logic [7:0] v);
        exp_t e;
        int   i;
        e.tag = tag;
        e.cyc = ecount + dly;
        e.sel = sel;
        e.exp = v;
        i = 0;
        while (i < sb_q.size() && sb_q[i].cyc <= e.cyc) i++;
        sb_q.insert(i, e);
    endtask

    task automatic do_reset(input logic [7:0] first);
        rst_n  = 1'b0;
        led_in = 8'h5A;
        tick(1);
        led_in = 8'hA5;
        tick(1);
        for (int s = 0; s < 8; s++) expect_at("reset_out", 0, s, 8'h00);
        rst_n  = 1'b1;
        led_in = first;
        expect_at("prime_nostep", 1, S_STEP, 8'h00);
        expect_at("prime_nostep", 2, S_STEP, 8'h00);
        expect_at("prime_nostep", 3, S_STEP, 8'h00);
        tick(10);
    endtask

    initial begin : stimulus
        // Left rotation, late step, relock and stall.
        do_reset(8'h01);
        led_in = 8'h02;
        expect_at("l1_valid_before", 1, S_VALID, 8'h00);
        expect_at("l1_step", 2, S_STEP, 8'h01);
        expect_at("l1_valid", 2, S_VALID, 8'h01);
        expect_at("l1_mode", 2, S_MODE, 8'h00);
        expect_at("l1_lock", 2, S_LOCK, 8'h00);
        expect_at("l1_step_end", 3, S_STEP, 8'h00);
        tick(10);
        led_in = 8'h04;
        expect_at("l2_step", 2, S_STEP, 8'h01);
        expect_at("l2_lock", 2, S_LOCK, 8'h00);
        tick(10);
        led_in = 8'h08;
        expect_at("l3_lock_before", 1, S_LOCK, 8'h00);
        expect_at("l3_step", 2, S_STEP, 8'h01);
        expect_at("l3_lock", 2, S_LOCK, 8'h01);
        expect_at("l3_mode", 2, S_MODE, 8'h00);
        expect_at("l3_ecnt", 2, S_ECNT, 8'h00);
        expect_at("late_no_terr", 12, S_TERR, 8'h00);
        tick(13);
        led_in = 8'h10;
        expect_at("late_step", 2, S_STEP, 8'h01);
        expect_at("late_terr", 2, S_TERR, 8'h01);
        expect_at("late_lock", 2, S_LOCK, 8'h00);
        expect_at("late_valid", 2, S_VALID, 8'h01);
        expect_at("late_ecnt", 2, S_ECNT, 8'h01);
        expect_at("late_serr", 2, S_SERR, 8'h00);
        expect_at("late_terr_end", 3, S_TERR, 8'h00);
        tick(10);
        led_in = 8'h20;
        expect_at("relock_lock0", 2, S_LOCK, 8'h00);
        tick(10);
        led_in = 8'h40;
        expect_at("relock_lock1", 2, S_LOCK, 8'h01);
        expect_at("stall_early", 14, S_TERR, 8'h00);
        expect_at("stall_terr", 15, S_TERR, 8'h01);
        expect_at("stall_valid", 15, S_VALID, 8'h00);
        expect_at("stall_mode", 15, S_MODE, 8'h00);
        expect_at("stall_lock", 15, S_LOCK, 8'h00);
        expect_at("stall_ecnt", 15, S_ECNT, 8'h02);
        expect_at("stall_terr_end", 16, S_TERR, 8'h00);
        expect_at("stall_ecnt_hold", 16, S_ECNT, 8'h02);
        tick(20);

        // Right rotation across the wrap point.
        do_reset(8'h02);
        led_in = 8'h01;
        expect_at("r1_step", 2, S_STEP, 8'h01);
        expect_at("r1_valid", 2, S_VALID, 8'h01);
        expect_at("r1_mode", 2, S_MODE, 8'h01);
        tick(10);
        led_in = 8'h80;
        expect_at("rwrap_step", 2, S_STEP, 8'h01);
        expect_at("rwrap_mode", 2, S_MODE, 8'h01);
        expect_at("rwrap_lock", 2, S_LOCK, 8'h00);
        tick(10);
        led_in = 8'h40;
        expect_at("r3_lock", 2, S_LOCK, 8'h01);
        expect_at("r3_mode", 2, S_MODE, 8'h01);
        expect_at("r3_ecnt", 2, S_ECNT, 8'h00);
        expect_at("r3_serr", 2, S_SERR, 8'h00);
        tick(10);

        // Alternate pattern with ambiguous AA<->55 steps.
        do_reset(8'h01);
        led_in = 8'hAA;
        expect_at("a1_mode", 2, S_MODE, 8'h03);
        expect_at("a1_valid", 2, S_VALID, 8'h01);
        expect_at("a1_lock", 2, S_LOCK, 8'h00);
        tick(10);
        led_in = 8'h55;
        expect_at("a2_step", 2, S_STEP, 8'h01);
        expect_at("a2_mode", 2, S_MODE, 8'h03);
        expect_at("a2_serr", 2, S_SERR, 8'h00);
        tick(10);
        led_in = 8'hAA;
        expect_at("a3_lock", 2, S_LOCK, 8'h01);
        expect_at("a3_mode", 2, S_MODE, 8'h03);
        expect_at("a3_ecnt", 2, S_ECNT, 8'h00);
        tick(10);

        // Mode change from left rotation to invert, with expected-mode check.
        check_en      = 1'b1;
        expected_mode = 2'b00;
        do_reset(8'h01);
        led_in = 8'h02;
        tick(10);
        led_in = 8'h04;
        tick(10);
        led_in = 8'h08;
        expect_at("mc_lock", 2, S_LOCK, 8'h01);
        expect_at("mc_mism0", 4, S_MISM, 8'h00);
        tick(10);
        led_in = 8'hF7;
        expect_at("mc_serr", 2, S_SERR, 8'h01);
        expect_at("mc_mode", 2, S_MODE, 8'h02);
        expect_at("mc_lock0", 2, S_LOCK, 8'h00);
        expect_at("mc_ecnt", 2, S_ECNT, 8'h01);
        expect_at("mc_valid", 2, S_VALID, 8'h01);
        expect_at("mc_serr_end", 3, S_SERR, 8'h00);
        expect_at("mc_mism_unlocked", 3, S_MISM, 8'h00);
        tick(10);
        led_in = 8'h08;
        expect_at("inv2_lock", 2, S_LOCK, 8'h00);
        expect_at("inv2_mode", 2, S_MODE, 8'h02);
        tick(10);
        led_in = 8'hF7;
        expect_at("inv3_lock", 2, S_LOCK, 8'h01);
        expect_at("inv3_mode", 2, S_MODE, 8'h02);
        expect_at("inv3_mism1", 4, S_MISM, 8'h01);
        tick(10);

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick(1);
        checks = checks + 1;
        assert (sb_q.size() == 0) else begin
            errors = errors + 1;
            $error("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
